// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame slave: receives {argA, argB, oper} frames and returns the
// execution-unit result and flags during the following frame.
module spi_frame_slave #(
    parameter int M     = 8,
    parameter int N     = 4,
    parameter int FRAME = 2 * M + N
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_sclk,
    input  logic         i_cs_n,
    input  logic         i_mosi,
    output logic         o_miso,
    output logic [M-1:0] o_argA,
    output logic [M-1:0] o_argB,
    output logic [N-1:0] o_oper,
    output logic         o_valid,
    output logic         o_err,
    input  logic [M-1:0] i_result,
    input  logic [3:0]   i_flags
);

    localparam int CW = $clog2(FRAME + 2);
    localparam logic [CW-1:0] FULL_C = CW'(FRAME);
    localparam logic [CW-1:0] SAT_C  = CW'(FRAME + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD,
        CAPTURE
    } state_t;

    // [0],[1] synchronize, [2] is the history flop for edge detection
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [2:0] mosi_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 3'b000;
        end else begin
            sclk_q <= {sclk_q[1:0], i_sclk};
            cs_q   <= {cs_q[1:0], i_cs_n};
            mosi_q <= {mosi_q[1:0], i_mosi};
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic cs_high;
    logic mosi_s;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_high   = cs_q[1];
    assign mosi_s    = mosi_q[2];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FRAME-1:0] rx_q, rx_d;
    logic [FRAME-1:0] tx_q, tx_d;
    logic            miso_q, miso_d;
    logic [M-1:0]    argA_q, argA_d;
    logic [M-1:0]    argB_q, argB_d;
    logic [N-1:0]    oper_q, oper_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            pend_q, pend_d;
    logic [FRAME-1:0] resp_w;

    // Response word: result, then flags OF first down to VF, zero padded
    assign resp_w = FRAME'({i_result, i_flags[0], i_flags[1],
                            i_flags[2], i_flags[3], {M{1'b0}}});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        miso_d  = 1'b0;
        argA_d  = argA_q;
        argB_d  = argB_q;
        oper_d  = oper_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        pend_d  = pend_q;

        unique case (state_q)
            IDLE: begin
                if (cs_fall || pend_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    miso_d  = tx_q[FRAME-1];
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (cnt_q == FULL_C) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[FRAME-2:0], mosi_s};
                        if (cnt_q != SAT_C) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (sclk_fall) begin
                        tx_d = {tx_q[FRAME-2:0], 1'b0};
                    end
                    miso_d = cs_high ? 1'b0 : tx_d[FRAME-1];
                end
            end
            LOAD: begin
                argA_d  = rx_q[FRAME-1 -: M];
                argB_d  = rx_q[FRAME-M-1 -: M];
                oper_d  = rx_q[N-1:0];
                valid_d = 1'b1;
                state_d = CAPTURE;
                if (cs_fall) begin
                    pend_d = 1'b1;
                end
            end
            CAPTURE: begin
                tx_d    = resp_w;
                state_d = IDLE;
                if (cs_fall) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            miso_q  <= 1'b0;
            argA_q  <= '0;
            argB_q  <= '0;
            oper_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            miso_q  <= miso_d;
            argA_q  <= argA_d;
            argB_q  <= argB_d;
            oper_q  <= oper_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign o_miso  = miso_q;
    assign o_argA  = argA_q;
    assign o_argB  = argB_q;
    assign o_oper  = oper_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: SPI master tasks, pulse monitor and a
// frame-level reference model of the request/response exchange.
module tb_spi_frame_slave;

    localparam int M     = 8;
    localparam int N     = 4;
    localparam int FRAME = 20;
    localparam int HALF  = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] argA, argB;
    logic [3:0] oper;
    logic       valid, err;
    logic [7:0] result;
    logic [3:0] flags;

    logic       stub_mode = 1'b0;
    logic [7:0] stub_res = 8'h00;
    logic [3:0] stub_flg = 4'h0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int valid_cyc = 0;
    int rise_cyc = 0;
    logic [19:0] exp_tx = 20'h0;

    always #5 clk = ~clk;

    // Execution-unit stand-in: returns {result, flags{VF,BF,SF,OF}}
    function automatic logic [11:0] exe(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [3:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        s = 9'h0;
        case (op[1:0])
            2'd0: s = {1'b0, a} + {1'b0, b};
            2'd1: s = {1'b0, a} - {1'b0, b};
            2'd2: s = {1'b0, a & b};
            default: s = {1'b0, a ^ b};
        endcase
        r = s[7:0];
        c = s[8];
        return {r, ^r, (b > a), r[7], c};
    endfunction

    function automatic logic [19:0] resp(input logic [7:0] r,
                                         input logic [3:0] f);
        return {r, f[0], f[1], f[2], f[3], 8'h00};
    endfunction

    assign {result, flags} = stub_mode ? exe(argA, argB, oper)
                                       : {stub_res, stub_flg};

    spi_frame_slave #(.M(M), .N(N), .FRAME(FRAME)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sclk   (sclk),
        .i_cs_n   (cs_n),
        .i_mosi   (mosi),
        .o_miso   (miso),
        .o_argA   (argA),
        .o_argB   (argB),
        .o_oper   (oper),
        .o_valid  (valid),
        .o_err    (err),
        .i_result (result),
        .i_flags  (flags)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic spi_bits(input logic [20:0] d, input int n,
                            output logic [20:0] got);
        got = 21'h0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            repeat (HALF) @(posedge clk);
            #1;
            got = {got[19:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [20:0] d, input int n,
                              input int gap, output logic [20:0] got);
        cs_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        spi_bits(d, n, got);
        repeat (HALF) @(posedge clk);
        #1;
        tests++;
        if (miso !== 1'b0) begin
            fails++;
            $display("FAIL miso_tail: got %b expected 0", miso);
        end
        cs_n = 1'b1;
        rise_cyc = cyc;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({miso, valid, err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctl: got %b expected 000",
                     {miso, valid, err});
        end
        tests++;
        if (argA !== 8'h00) begin
            fails++;
            $display("FAIL reset_argA: got %h expected 00", argA);
        end
        tests++;
        if (argB !== 8'h00) begin
            fails++;
            $display("FAIL reset_argB: got %h expected 00", argB);
        end
        tests++;
        if (oper !== 4'h0) begin
            fails++;
            $display("FAIL reset_oper: got %h expected 0", oper);
        end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_tx = 20'h0;
    endtask

    task automatic check_fields(input string nm, input logic [7:0] a,
                                input logic [7:0] b, input logic [3:0] op);
        tests++;
        if ({argA, argB, oper} !== {a, b, op}) begin
            fails++;
            $display("FAIL %s_fields: got %h/%h/%h expected %h/%h/%h",
                     nm, argA, argB, oper, a, b, op);
        end
    endtask

    task automatic test_basic();
        logic [20:0] got;
        int v0, e0;
        stub_mode = 1'b0;
        stub_res  = 8'h08;
        stub_flg  = 4'b0000;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame({1'b0, 8'h05, 8'h03, 4'h0}, FRAME, 10, got);
        tests++;
        if (got[19:0] !== 20'h0) begin
            fails++;
            $display("FAIL first_miso: got %h expected 00000", got[19:0]);
        end
        tests++;
        if (valid_cnt - v0 != 1 || err_cnt != e0) begin
            fails++;
            $display("FAIL basic_pulses: valid %0d err %0d expected 1 0",
                     valid_cnt - v0, err_cnt - e0);
        end
        tests++;
        if (valid_cyc - rise_cyc != 4) begin
            fails++;
            $display("FAIL valid_latency: got %0d expected 4",
                     valid_cyc - rise_cyc);
        end
        check_fields("basic", 8'h05, 8'h03, 4'h0);
        exp_tx = resp(stub_res, stub_flg);

        stub_res = 8'hFF;
        stub_flg = 4'b0011;
        send_frame({1'b0, 8'hA5, 8'h5A, 4'h3}, FRAME, 10, got);
        tests++;
        if (got[19:0] !== exp_tx || exp_tx !== 20'h08000) begin
            fails++;
            $display("FAIL resp_08: got %h expected 08000", got[19:0]);
        end
        check_fields("second", 8'hA5, 8'h5A, 4'h3);
        exp_tx = resp(stub_res, stub_flg);

        send_frame({1'b0, 8'h11, 8'h22, 4'h9}, FRAME, 10, got);
        tests++;
        if (got[19:0] !== 20'hFFC00) begin
            fails++;
            $display("FAIL resp_ff: got %h expected FFC00", got[19:0]);
        end
        exp_tx = resp(stub_res, stub_flg);
    endtask

    task automatic test_bad_length();
        logic [20:0] got;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(21'h0ABCDE, 19, 10, got);
        tests++;
        if (got[18:0] !== exp_tx[19:1]) begin
            fails++;
            $display("FAIL short_miso: got %h expected %h",
                     got[18:0], exp_tx[19:1]);
        end
        exp_tx = exp_tx << 19;
        tests++;
        if (err_cnt - e0 != 1 || valid_cnt != v0) begin
            fails++;
            $display("FAIL short_pulses: err %0d valid %0d expected 1 0",
                     err_cnt - e0, valid_cnt - v0);
        end
        check_fields("short_hold", 8'h11, 8'h22, 4'h9);
        send_frame(21'h1FFFFF, 21, 10, got);
        exp_tx = 20'h0;
        tests++;
        if (err_cnt - e0 != 2 || valid_cnt != v0) begin
            fails++;
            $display("FAIL long_pulses: err %0d valid %0d expected 2 0",
                     err_cnt - e0, valid_cnt - v0);
        end
        check_fields("long_hold", 8'h11, 8'h22, 4'h9);
        send_frame({1'b0, 8'h33, 8'h44, 4'h2}, FRAME, 10, got);
        tests++;
        if (got[19:0] !== exp_tx) begin
            fails++;
            $display("FAIL after_err_miso: got %h expected %h",
                     got[19:0], exp_tx);
        end
        check_fields("after_err", 8'h33, 8'h44, 4'h2);
        exp_tx = resp(stub_res, stub_flg);
    endtask

    task automatic test_mid_reset();
        logic [20:0] got;
        int v0, e0;
        e0 = err_cnt;
        cs_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        spi_bits(21'h155555, 10, got);
        rst_n = 1'b0;
        #2;
        tests++;
        if ({argA, miso, valid} !== 10'h0) begin
            fails++;
            $display("FAIL async_reset: got %h/%b/%b expected 00/0/0",
                     argA, miso, valid);
        end
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        exp_tx = 20'h0;
        stub_res = 8'h5C;
        stub_flg = 4'b1010;
        v0 = valid_cnt;
        send_frame({1'b0, 8'hC3, 8'h7E, 4'hB}, FRAME, 10, got);
        tests++;
        if (valid_cnt - v0 != 1 || err_cnt != e0) begin
            fails++;
            $display("FAIL mid_reset_pulses: valid %0d err %0d expected 1 0",
                     valid_cnt - v0, err_cnt - e0);
        end
        tests++;
        if (got[19:0] !== 20'h0) begin
            fails++;
            $display("FAIL mid_reset_miso: got %h expected 00000",
                     got[19:0]);
        end
        check_fields("mid_reset", 8'hC3, 8'h7E, 4'hB);
        exp_tx = resp(stub_res, stub_flg);
    endtask

    task automatic test_back_to_back();
        logic [20:0] got;
        logic [7:0]  a, b;
        logic [3:0]  op;
        logic [11:0] rf;
        int v0, e0;
        stub_mode = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int k = 0; k < 50; k++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 4'($urandom);
            send_frame({1'b0, a, b, op}, FRAME, 4, got);
            tests++;
            if (got[19:0] !== exp_tx) begin
                fails++;
                $display("FAIL b2b_miso[%0d]: got %h expected %h",
                         k, got[19:0], exp_tx);
            end
            tests++;
            if ({argA, argB, oper} !== {a, b, op}) begin
                fails++;
                $display("FAIL b2b_fields[%0d]: got %h/%h/%h expected %h/%h/%h",
                         k, argA, argB, oper, a, b, op);
            end
            rf = exe(a, b, op);
            exp_tx = resp(rf[11:4], rf[3:0]);
        end
        send_frame(21'h0, FRAME, 10, got);
        tests++;
        if (got[19:0] !== exp_tx) begin
            fails++;
            $display("FAIL b2b_last_miso: got %h expected %h",
                     got[19:0], exp_tx);
        end
        tests++;
        if (valid_cnt - v0 != 51 || err_cnt != e0) begin
            fails++;
            $display("FAIL b2b_pulses: valid %0d err %0d expected 51 0",
                     valid_cnt - v0, err_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_length();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_frame_slave.md
SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

Interface
REQ-001 Parameter M, default 8: argument/result width of the downstream execution unit.
REQ-002 Parameter N, default 4: operation-code width; flag count is fixed at 4.
REQ-003 Parameter FRAME, default 2*M+N (20): SPI frame length in bits.
REQ-004 i_clk  input  1  system clock; all state on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_sclk  input  1  SPI clock, asynchronous to i_clk; at most i_clk/8.
REQ-007 i_cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-008 i_mosi  input  1  SPI data in, asynchronous.
REQ-009 o_miso  output  1  SPI data out, registered in i_clk domain.
REQ-010 o_argA  output  M  received argument A, frame bits [FRAME-1 -: M].
REQ-011 o_argB  output  M  received argument B, next M bits.
REQ-012 o_oper  output  N  received operation code, last N bits.
REQ-013 o_valid  output  1  one-cycle pulse: o_argA/o_argB/o_oper updated.
REQ-014 o_err  output  1  one-cycle pulse: frame dropped (bit count != FRAME).
REQ-015 i_result  input  M  execution-unit result, combinational from o_argA/o_argB/o_oper.
REQ-016 i_flags  input  4  {VF,BF,SF,OF} from execution unit (bit0 = OF).

Function
REQ-017 i_sclk, i_cs_n, i_mosi SHALL each pass a 2-flop synchronizer plus one history flop for edge detection; i_cs_n synchronizer resets to 1.
REQ-018 SPI mode 0, MSB first: MOSI sampled on synchronized SCLK rising edge, MISO shifted on synchronized SCLK falling edge.
REQ-019 FSM states: IDLE, SHIFT, LOAD, CAPTURE.
REQ-020 IDLE -> SHIFT on synchronized CS falling edge; bit counter cleared; tx shift register MSB driven on o_miso next cycle.
REQ-021 SHIFT: each SCLK rising edge shifts synchronized MOSI into rx register LSB and increments the bit counter, saturating at FRAME+1.
REQ-022 SHIFT -> LOAD on CS rising edge with counter == FRAME; SHIFT -> IDLE with o_err pulse on CS rising edge with counter != FRAME (short or long frame); outputs unchanged on error.
REQ-023 LOAD (one cycle): o_argA/o_argB/o_oper loaded from rx register, o_valid = 1; next state CAPTURE.
REQ-024 CAPTURE (one cycle): tx register loaded with {i_result, i_flags[0], i_flags[1], i_flags[2], i_flags[3], M zeros} (20 bits: result, OF, SF, BF, VF, 8 zeros); next state IDLE.
REQ-025 Response to frame k SHALL be shifted out on o_miso during frame k+1; first frame after reset returns all zeros.
REQ-026 o_miso SHALL be 0 while CS is high (synchronized) and SHALL present tx bits MSB first while low; after FRAME bits shifted, o_miso = 0.
REQ-027 CS falling edge arriving during LOAD or CAPTURE SHALL be honoured: FSM enters SHIFT after CAPTURE completes, tx register already updated; bench keeps >= 4 i_clk from CS rise to CS fall.
REQ-028 SCLK edges while CS high SHALL be ignored; rx register and counter unchanged.
REQ-029 Latency: o_valid asserts 3 i_clk after raw i_cs_n rise (2 sync + 1 edge detect) plus one LOAD cycle, i.e. fixed 4 cycles; tx capture one cycle after o_valid.

Reset
REQ-030 On i_rst_n low, immediately: FSM IDLE, o_miso 0, o_argA/o_argB/o_oper 0, o_valid 0, o_err 0, rx/tx registers 0, counter 0.
REQ-031 Reset mid-frame SHALL discard the partial frame without o_err; after release, next CS falling edge starts a fresh frame.

Verification
REQ-032 Frame 20'b00000101_00000011_0000, stub i_result = 8'h08, i_flags = 4'b0000 -> o_valid one cycle, o_argA = 8'h05, o_argB = 8'h03, o_oper = 4'h0; next frame shifts out 20'b00001000_0000_00000000 on o_miso.
REQ-033 Stub i_result = 8'hFF, i_flags = 4'b0011 (OF,SF) -> next frame o_miso = 20'b11111111_1100_00000000.
REQ-034 CS high after 19 bits -> o_err pulse, no o_valid, o_argA/o_argB/o_oper hold previous values; after 21 bits -> same.
REQ-035 First frame after reset -> o_miso all 20 bits 0.
REQ-036 Assert i_rst_n low after 10 bits, release, send a full valid frame -> o_valid once, correct fields, no o_err.
REQ-037 Back-to-back frames with 4 i_clk CS-high gap, 50 random frames against exe_unit -> each o_miso response equals the execution-unit output for the previous frame.
